// File: rtl/product_accumulator.sv
// product_accumulator
//   Sums COUNT consecutive 8-bit products taken over a valid/ready input and
//   presents the sum, with a sticky wrap flag, on a valid/ready output.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   ACC   | collecting products; in_ready high unless clr is asserted
//   HOLD  | result presented on acc_out/acc_ovf until out_ready
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   prod       unsigned product from the multiplier
//   in_valid   prod is valid this cycle
//   in_ready   block accepts prod this cycle
//   clr        discard the partial sum (ignored in HOLD)
//   acc_out    accumulated result
//   acc_ovf    result wrapped past 2^ACC_W-1
//   out_valid  acc_out/acc_ovf valid
//   out_ready  consumer takes the result this cycle
module product_accumulator #(
  parameter int ACC_W = 12,
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       prod,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clr,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CNT_W = (COUNT <= 1) ? 1 : $clog2(COUNT);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic [ACC_W:0]   sum;
  logic             last;

  assign in_ready = (state == ACC) && !clr;

  // One extra bit on the adder captures the carry-out that feeds the sticky flag.
  assign sum  = {1'b0, acc} + {{(ACC_W + 1 - 8){1'b0}}, prod};
  assign last = (cnt == CNT_W'(COUNT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      acc_out   <= '0;
      acc_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (clr) begin
            acc <= '0;
            ovf <= 1'b0;
            cnt <= '0;
          end else if (in_valid) begin
            if (last) begin
              acc_out   <= sum[ACC_W-1:0];
              acc_ovf   <= ovf | sum[ACC_W];
              out_valid <= 1'b1;
              acc       <= '0;
              ovf       <= 1'b0;
              cnt       <= '0;
              state     <= HOLD;
            end else begin
              acc <= sum[ACC_W-1:0];
              ovf <= ovf | sum[ACC_W];
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // instance a: defaults (ACC_W=12, COUNT=4)
  logic [7:0]  prod_a;
  logic        in_valid_a, in_ready_a, clr_a, acc_ovf_a, out_valid_a, out_ready_a;
  logic [11:0] acc_out_a;

  // instance b: ACC_W=8, COUNT=2
  logic [7:0]  prod_b;
  logic        in_valid_b, in_ready_b, clr_b, acc_ovf_b, out_valid_b, out_ready_b;
  logic [7:0]  acc_out_b;

  product_accumulator u_a (
    .clk(clk), .rst(rst), .prod(prod_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .clr(clr_a), .acc_out(acc_out_a), .acc_ovf(acc_ovf_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a)
  );

  product_accumulator #(.ACC_W(8), .COUNT(2)) u_b (
    .clk(clk), .rst(rst), .prod(prod_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .clr(clr_b), .acc_out(acc_out_b), .acc_ovf(acc_ovf_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b)
  );

  typedef struct {
    logic [31:0] acc;
    logic        ovf;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  // Monitors: compare each output handshake against the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid_a && out_ready_a) begin
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected actual acc %0d required no result", acc_out_a);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        chk("a_acc_out", {20'd0, acc_out_a}, e.acc);
        chk("a_acc_ovf", {31'd0, acc_ovf_a}, {31'd0, e.ovf});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid_b && out_ready_b) begin
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected actual acc %0d required no result", acc_out_b);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        chk("b_acc_out", {24'd0, acc_out_b}, e.acc);
        chk("b_acc_ovf", {31'd0, acc_ovf_b}, {31'd0, e.ovf});
      end
    end
  end

  task automatic expect_res(input bit inst_b, input int acc, input bit ovf);
    exp_t e;
    e.acc = acc;
    e.ovf = ovf;
    if (inst_b) q_b.push_back(e);
    else        q_a.push_back(e);
  endtask

  // Offers one product with gap idle cycles first; returns at posedge+1 after acceptance.
  task automatic send(input bit inst_b, input logic [7:0] p, input int gap);
    bit done;
    done = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    if (inst_b) begin in_valid_b = 1'b1; prod_b = p; end
    else        begin in_valid_a = 1'b1; prod_a = p; end
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (inst_b ? in_ready_b : in_ready_a) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (inst_b) in_valid_b = 1'b0;
    else        in_valid_a = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual in_ready low for 50 cycles required acceptance");
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    prod_a = '0; in_valid_a = 1'b0; clr_a = 1'b0; out_ready_a = 1'b1;
    prod_b = '0; in_valid_b = 1'b0; clr_b = 1'b0; out_ready_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    chk("rst_out_valid", {31'd0, out_valid_a}, 0);
    chk("rst_acc_out", {20'd0, acc_out_a}, 0);
    chk("rst_acc_ovf", {31'd0, acc_ovf_a}, 0);
    chk("rst_in_ready", {31'd0, in_ready_a}, 1);

    // T1: 225 x4 back-to-back
    expect_res(1'b0, 900, 1'b0);
    for (int i = 0; i < 4; i++) send(1'b0, 8'd225, 0);
    chk("t1_valid_on_4th", {31'd0, out_valid_a}, 1);
    step();
    chk("t1_valid_one_cycle", {31'd0, out_valid_a}, 0);
    chk("t1_in_ready_back", {31'd0, in_ready_a}, 1);
    chk("t1_acc_kept", {20'd0, acc_out_a}, 900);

    // T2: ACC_W=8, COUNT=2 wrap, then sticky flag cleared
    expect_res(1'b1, 44, 1'b1);
    send(1'b1, 8'd200, 0);
    send(1'b1, 8'd100, 0);
    expect_res(1'b1, 7, 1'b0);
    send(1'b1, 8'd3, 0);
    send(1'b1, 8'd4, 0);
    step();

    // T3: backpressure
    out_ready_a = 1'b0;
    expect_res(1'b0, 10, 1'b0);
    send(1'b0, 8'd1, 0);
    send(1'b0, 8'd2, 0);
    send(1'b0, 8'd3, 0);
    send(1'b0, 8'd4, 0);
    for (int i = 0; i < 5; i++) begin
      in_valid_a = i[0];
      prod_a = 8'd99;
      @(negedge clk);
      chk("t3_out_valid", {31'd0, out_valid_a}, 1);
      chk("t3_acc_out", {20'd0, acc_out_a}, 10);
      chk("t3_in_ready", {31'd0, in_ready_a}, 0);
      @(posedge clk);
      #1;
    end
    in_valid_a = 1'b0;
    out_ready_a = 1'b1;
    step();
    chk("t3_released", {31'd0, out_valid_a}, 0);

    // T4: clr discards partial sum, blocks simultaneous product
    send(1'b0, 8'd5, 0);
    send(1'b0, 8'd6, 0);
    clr_a = 1'b1; in_valid_a = 1'b1; prod_a = 8'd7;
    @(negedge clk);
    chk("t4_in_ready_clr", {31'd0, in_ready_a}, 0);
    @(posedge clk);
    #1;
    clr_a = 1'b0; in_valid_a = 1'b0;
    expect_res(1'b0, 10, 1'b0);
    for (int i = 1; i <= 4; i++) send(1'b0, 8'(i), 0);
    step();

    // T5: reset mid-accumulation, then reset while holding
    send(1'b0, 8'd50, 0);
    send(1'b0, 8'd60, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_rst_valid", {31'd0, out_valid_a}, 0);
    chk("t5_rst_acc", {20'd0, acc_out_a}, 0);
    expect_res(1'b0, 4, 1'b0);
    for (int i = 0; i < 4; i++) send(1'b0, 8'd1, 0);
    step();
    out_ready_a = 1'b0;
    for (int i = 1; i <= 4; i++) send(1'b0, 8'(i), 0);
    chk("t5_hold_valid", {31'd0, out_valid_a}, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_hold_rst_valid", {31'd0, out_valid_a}, 0);
    chk("t5_hold_rst_ready", {31'd0, in_ready_a}, 1);
    out_ready_a = 1'b1;

    // T6: random gaps
    expect_res(1'b0, 54, 1'b0);
    send(1'b0, 8'd15, $urandom_range(0, 3));
    send(1'b0, 8'd14, $urandom_range(0, 3));
    send(1'b0, 8'd13, $urandom_range(0, 3));
    send(1'b0, 8'd12, $urandom_range(0, 3));
    repeat (4) step();

    chk("a_queue_drained", q_a.size(), 0);
    chk("b_queue_drained", q_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
